// File: rtl/kf8259_acknowledge_sequencer_if.sv
// kf8259_acknowledge_sequencer_if: request/ISR inputs, INTA handshake, OCW2 and vector bus of the acknowledge sequencer
interface kf8259_acknowledge_sequencer_if;
  logic [7:0] interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic       interrupt_acknowledge_n;
  logic       write_ocw2;
  logic [7:0] ocw2_data;
  logic       auto_eoi_config;
  logic [4:0] vector_base;
  logic       interrupt_to_cpu;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic       out_control_logic_data;
  logic [7:0] control_logic_data;
  modport slave (
    input  interrupt_request, in_service_register, highest_level_in_service, interrupt_acknowledge_n,
           write_ocw2, ocw2_data, auto_eoi_config, vector_base,
    output interrupt_to_cpu, latch_in_service, interrupt, end_of_interrupt, priority_rotate,
           out_control_logic_data, control_logic_data
  );
  modport master (
    output interrupt_request, in_service_register, highest_level_in_service, interrupt_acknowledge_n,
           write_ocw2, ocw2_data, auto_eoi_config, vector_base,
    input  interrupt_to_cpu, latch_in_service, interrupt, end_of_interrupt, priority_rotate,
           out_control_logic_data, control_logic_data
  );
endinterface

// File: rtl/kf8259_acknowledge_sequencer.sv
// kf8259_acknowledge_sequencer: priority resolution, 8086 two-pulse INTA sequencing, vector drive and OCW2 EOI/rotate
module kf8259_acknowledge_sequencer #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input logic clock,
  input logic reset,
  kf8259_acknowledge_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;
  state_t state, state_n;
  logic inta_prev, inta_fall, inta_rise;
  logic rotate_in_aeoi, rotate_in_aeoi_n;
  logic spurious, spurious_n;
  logic [2:0] level, level_n, rot, ocw2_level;
  logic [7:0] rreq, rhi, rwin, rel, eligible, ocw2_onehot;
  logic [15:0] rreq2, rhi2, rel2;
  logic int_n, latch_n, drive_n;
  logic [7:0] interrupt_n, eoi_n, data_n;
  logic [2:0] rotate_n;
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    onehot_index = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) onehot_index = 3'(i);
  endfunction
  assign inta_fall = inta_prev & ~bus.interrupt_acknowledge_n;
  assign inta_rise = ~inta_prev & bus.interrupt_acknowledge_n;
  assign ocw2_level = bus.ocw2_data[2:0];
  assign ocw2_onehot = 8'd1 << ocw2_level;
  // rotate so the highest-priority level sits at bit 0, pick lowest set bit, gate by in-service level, rotate back
  always_comb begin
    rot = bus.priority_rotate + 3'd1;
    rreq2 = {bus.interrupt_request, bus.interrupt_request} >> rot;
    rhi2 = {bus.highest_level_in_service, bus.highest_level_in_service} >> rot;
    rreq = rreq2[7:0];
    rhi = rhi2[7:0];
    rwin = rreq & (~rreq + 8'd1);
    rel = rwin & ((rhi == 8'd0) ? 8'hFF : rhi - 8'd1);
    rel2 = {rel, rel} << rot;
    eligible = rel2[15:8];
  end
  always_comb begin
    state_n = state;
    int_n = bus.interrupt_to_cpu;
    latch_n = 1'b0;
    interrupt_n = bus.interrupt;
    eoi_n = 8'd0;
    rotate_n = bus.priority_rotate;
    drive_n = bus.out_control_logic_data;
    data_n = bus.control_logic_data;
    level_n = level;
    spurious_n = spurious;
    rotate_in_aeoi_n = rotate_in_aeoi;
    case (state)
      IDLE: if (eligible != 8'd0) begin
        int_n = 1'b1;
        state_n = PEND;
      end
      PEND: if (inta_fall) begin
        int_n = 1'b0;
        interrupt_n = eligible;
        latch_n = |eligible;
        spurious_n = ~|eligible;
        level_n = |eligible ? onehot_index(eligible) : SPURIOUS_LEVEL;
        state_n = ACK1;
      end
      ACK1: if (inta_rise) state_n = WAIT2;
      WAIT2: if (inta_fall) begin
        drive_n = 1'b1;
        data_n = {bus.vector_base, level};
        state_n = ACK2;
      end
      ACK2: if (inta_rise) begin
        drive_n = 1'b0;
        data_n = 8'd0;
        interrupt_n = 8'd0;
        eoi_n = (bus.auto_eoi_config && !spurious) ? bus.interrupt : 8'd0;
        rotate_n = (bus.auto_eoi_config && !spurious && rotate_in_aeoi) ? level : bus.priority_rotate;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // OCW2 applies last so its rotate update overrides the AEOI one while EOIs merge
    if (bus.write_ocw2) begin
      case (bus.ocw2_data[7:5])
        3'b001: eoi_n = eoi_n | bus.highest_level_in_service;
        3'b011: eoi_n = eoi_n | ocw2_onehot;
        3'b101: begin
          eoi_n = eoi_n | bus.highest_level_in_service;
          if (|bus.highest_level_in_service) rotate_n = onehot_index(bus.highest_level_in_service);
        end
        3'b111: begin
          eoi_n = eoi_n | ocw2_onehot;
          rotate_n = ocw2_level;
        end
        3'b110: rotate_n = ocw2_level;
        3'b100: rotate_in_aeoi_n = 1'b1;
        3'b000: rotate_in_aeoi_n = 1'b0;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      inta_prev <= 1'b1;
      rotate_in_aeoi <= 1'b0;
      spurious <= 1'b0;
      level <= 3'd0;
      bus.interrupt_to_cpu <= 1'b0;
      bus.latch_in_service <= 1'b0;
      bus.interrupt <= 8'd0;
      bus.end_of_interrupt <= 8'd0;
      bus.priority_rotate <= 3'b111;
      bus.out_control_logic_data <= 1'b0;
      bus.control_logic_data <= 8'd0;
    end else begin
      state <= state_n;
      inta_prev <= bus.interrupt_acknowledge_n;
      rotate_in_aeoi <= rotate_in_aeoi_n;
      spurious <= spurious_n;
      level <= level_n;
      bus.interrupt_to_cpu <= int_n;
      bus.latch_in_service <= latch_n;
      bus.interrupt <= interrupt_n;
      bus.end_of_interrupt <= eoi_n;
      bus.priority_rotate <= rotate_n;
      bus.out_control_logic_data <= drive_n;
      bus.control_logic_data <= data_n;
    end
  end
endmodule

// File: tb/tb_kf8259_acknowledge_sequencer.sv
// tb_kf8259_acknowledge_sequencer: directed steps with hand-computed expectations for the acknowledge sequencer
module tb_kf8259_acknowledge_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  kf8259_acknowledge_sequencer_if b ();
  kf8259_acknowledge_sequencer dut (.clock(clock), .reset(reset), .bus(b));
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // full two-pulse INTA cycle starting in PEND; request is withdrawn once the first pulse is taken
  task automatic ack(input string tag, input logic [7:0] irq, input logic lat, input logic [7:0] vec, input logic [7:0] eoi);
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    chk({tag, " latch"}, 8'(b.latch_in_service), 8'(lat));
    chk({tag, " interrupt"}, b.interrupt, irq);
    chk({tag, " int drop"}, 8'(b.interrupt_to_cpu), 8'd0);
    b.interrupt_request = 8'd0;
    b.interrupt_acknowledge_n = 1'b1;
    tick();
    chk({tag, " latch pulse"}, 8'(b.latch_in_service), 8'd0);
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    chk({tag, " drive"}, 8'(b.out_control_logic_data), 8'd1);
    chk({tag, " vector"}, b.control_logic_data, vec);
    b.interrupt_acknowledge_n = 1'b1;
    tick();
    chk({tag, " release"}, 8'(b.out_control_logic_data), 8'd0);
    chk({tag, " aeoi"}, b.end_of_interrupt, eoi);
    tick();
    chk({tag, " eoi end"}, b.end_of_interrupt, 8'd0);
    chk({tag, " idle int"}, 8'(b.interrupt_to_cpu), 8'd0);
  endtask
  initial begin
    b.interrupt_request = 8'd0;
    b.in_service_register = 8'd0;
    b.highest_level_in_service = 8'd0;
    b.interrupt_acknowledge_n = 1'b1;
    b.write_ocw2 = 1'b0;
    b.ocw2_data = 8'd0;
    b.auto_eoi_config = 1'b0;
    b.vector_base = 5'h12;
    tick();
    tick();
    chk("rst int", 8'(b.interrupt_to_cpu), 8'd0);
    chk("rst latch", 8'(b.latch_in_service), 8'd0);
    chk("rst interrupt", b.interrupt, 8'd0);
    chk("rst eoi", b.end_of_interrupt, 8'd0);
    chk("rst rotate", 8'(b.priority_rotate), 8'd7);
    chk("rst drive", 8'(b.out_control_logic_data), 8'd0);
    chk("rst data", b.control_logic_data, 8'd0);
    reset = 1'b1;
    b.interrupt_request = 8'h04;
    tick();
    chk("t1 int", 8'(b.interrupt_to_cpu), 8'd1);
    ack("t1", 8'h04, 1'b1, 8'h92, 8'h00);
    b.in_service_register = 8'h02;
    b.highest_level_in_service = 8'h02;
    b.interrupt_request = 8'h08;
    tick();
    tick();
    chk("t2 nested block", 8'(b.interrupt_to_cpu), 8'd0);
    b.in_service_register = 8'h00;
    b.highest_level_in_service = 8'h00;
    tick();
    chk("t2 int", 8'(b.interrupt_to_cpu), 8'd1);
    b.interrupt_request = 8'h01;
    tick();
    b.interrupt_request = 8'h09;
    ack("t2", 8'h01, 1'b1, 8'h90, 8'h00);
    b.auto_eoi_config = 1'b1;
    b.interrupt_request = 8'h10;
    tick();
    chk("t3 int", 8'(b.interrupt_to_cpu), 8'd1);
    b.interrupt_request = 8'h00;
    tick();
    chk("t3 int held", 8'(b.interrupt_to_cpu), 8'd1);
    ack("t3 spurious", 8'h00, 1'b0, 8'h97, 8'h00);
    b.write_ocw2 = 1'b1;
    b.ocw2_data = 8'h80;
    tick();
    b.write_ocw2 = 1'b0;
    chk("t4 ocw2 80 eoi", b.end_of_interrupt, 8'h00);
    chk("t4 ocw2 80 rotate", 8'(b.priority_rotate), 8'd7);
    b.interrupt_request = 8'h08;
    tick();
    chk("t4 int", 8'(b.interrupt_to_cpu), 8'd1);
    ack("t4", 8'h08, 1'b1, 8'h93, 8'h08);
    chk("t4 rotate", 8'(b.priority_rotate), 8'd3);
    b.write_ocw2 = 1'b1;
    b.ocw2_data = 8'hE5;
    tick();
    b.write_ocw2 = 1'b0;
    chk("t5 E5 eoi", b.end_of_interrupt, 8'h20);
    chk("t5 E5 rotate", 8'(b.priority_rotate), 8'd5);
    tick();
    chk("t5 E5 eoi end", b.end_of_interrupt, 8'h00);
    b.highest_level_in_service = 8'h40;
    b.write_ocw2 = 1'b1;
    b.ocw2_data = 8'h20;
    tick();
    b.write_ocw2 = 1'b0;
    b.highest_level_in_service = 8'h00;
    chk("t5 20 eoi", b.end_of_interrupt, 8'h40);
    chk("t5 20 rotate", 8'(b.priority_rotate), 8'd5);
    b.interrupt_request = 8'h08;
    tick();
    chk("t6 int", 8'(b.interrupt_to_cpu), 8'd1);
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    chk("t6 latch", 8'(b.latch_in_service), 8'd1);
    b.interrupt_request = 8'h00;
    b.interrupt_acknowledge_n = 1'b1;
    tick();
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    chk("t6 drive", 8'(b.out_control_logic_data), 8'd1);
    chk("t6 vector", b.control_logic_data, 8'h93);
    reset = 1'b0;
    b.interrupt_acknowledge_n = 1'b1;
    tick();
    chk("t6 rst drive", 8'(b.out_control_logic_data), 8'd0);
    chk("t6 rst eoi", b.end_of_interrupt, 8'h00);
    chk("t6 rst rotate", 8'(b.priority_rotate), 8'd7);
    chk("t6 rst interrupt", b.interrupt, 8'h00);
    reset = 1'b1;
    tick();
    chk("t6 no late eoi", b.end_of_interrupt, 8'h00);
    chk("t6 idle int", 8'(b.interrupt_to_cpu), 8'd0);
    b.interrupt_request = 8'h08;
    tick();
    chk("t6b int", 8'(b.interrupt_to_cpu), 8'd1);
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    b.interrupt_request = 8'h00;
    b.interrupt_acknowledge_n = 1'b1;
    tick();
    b.interrupt_acknowledge_n = 1'b0;
    tick();
    b.interrupt_acknowledge_n = 1'b1;
    b.write_ocw2 = 1'b1;
    b.ocw2_data = 8'h61;
    tick();
    b.write_ocw2 = 1'b0;
    chk("t6b merged eoi", b.end_of_interrupt, 8'h0A);
    chk("t6b rotate", 8'(b.priority_rotate), 8'd7);
    tick();
    chk("t6b eoi end", b.end_of_interrupt, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
